// File: rtl/switch_allocator_pkg.sv
// Shared types and width helpers for the switch allocator: slot FSM states
// and index-width arithmetic used by the interface, top and arbiters.
package switch_allocator_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } alloc_state_t;

  localparam int DEF_NUM_BUFFERS  = 4;
  localparam int DEF_NUM_OUTPORTS = 4;
  localparam int DEF_NUM_VCS      = 2;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rr_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// Request/grant bundle between the input buffers and the switch allocator.
// The allocator modport drives the per-slot crossbar select/enable.
interface switch_allocator_if #(
  parameter int NUM_BUFFERS  = switch_allocator_pkg::DEF_NUM_BUFFERS,
  parameter int NUM_OUTPORTS = switch_allocator_pkg::DEF_NUM_OUTPORTS,
  parameter int NUM_VCS      = switch_allocator_pkg::DEF_NUM_VCS
) ();

  localparam int SELECT_SIZE = switch_allocator_pkg::idx_w(NUM_BUFFERS);
  localparam int OUTPORT_W   = switch_allocator_pkg::idx_w(NUM_OUTPORTS);
  localparam int VC_W        = switch_allocator_pkg::idx_w(NUM_VCS);

  logic [NUM_BUFFERS-1:0]                                 valid;
  logic [NUM_BUFFERS-1:0][OUTPORT_W-1:0]                  req_outport;
  logic [NUM_BUFFERS-1:0][VC_W-1:0]                       req_vc;
  logic                                                   reg_bank_claim;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][SELECT_SIZE-1:0]  select;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]                   enable;
  logic [NUM_BUFFERS-1:0]                                 grant;

  modport allocator (
    input  valid, req_outport, req_vc, reg_bank_claim,
    output select, enable, grant
  );

  modport client (
    output valid, req_outport, req_vc, reg_bank_claim,
    input  select, enable, grant
  );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority at ptr, scanning
// upward with wrap; reports the first requester found.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = switch_allocator_pkg::idx_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any_grant
);
  import switch_allocator_pkg::*;

  logic [W-1:0] cand;

  always_comb begin
    winner    = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = W'(rr_idx(int'(ptr), i, N));
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Switch allocator: one round-robin arbiter and two-state wormhole FSM per
// (outport, VC) slot; a slot stays locked to its owner until valid drops.
module switch_allocator #(
  parameter int NUM_BUFFERS  = 4,
  parameter int NUM_OUTPORTS = 4,
  parameter int NUM_VCS      = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  switch_allocator_if.allocator bus
);
  import switch_allocator_pkg::*;

  localparam int SEL_W     = idx_w(NUM_BUFFERS);
  localparam int NUM_SLOTS = NUM_OUTPORTS * NUM_VCS;

  logic [NUM_BUFFERS-1:0]                 qual;
  logic [NUM_BUFFERS-1:0]                 owns;
  logic [NUM_SLOTS-1:0][NUM_BUFFERS-1:0]  slot_req;
  logic [NUM_SLOTS-1:0][SEL_W-1:0]        winner;
  logic [NUM_SLOTS-1:0][SEL_W-1:0]        owner_q;
  logic [NUM_SLOTS-1:0][SEL_W-1:0]        ptr_q;
  logic [NUM_SLOTS-1:0]                   any_win;
  logic [NUM_SLOTS-1:0]                   load;
  alloc_state_t                           state_q [NUM_SLOTS];
  alloc_state_t                           state_d [NUM_SLOTS];

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
    return (idx == SEL_W'(NUM_BUFFERS - 1)) ? '0 : idx + 1'b1;
  endfunction

  // A buffer that already owns a slot, or asks for a nonexistent slot, is
  // kept out of every arbiter.
  always_comb begin
    qual     = '0;
    slot_req = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      qual[b] = bus.valid[b] && !owns[b] &&
                (int'(bus.req_outport[b]) < NUM_OUTPORTS) &&
                (int'(bus.req_vc[b]) < NUM_VCS);
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_req[s][b] = qual[b] &&
          ((int'(bus.req_outport[b]) * NUM_VCS + int'(bus.req_vc[b])) == s);
      end
    end
  end

  for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
    rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
      .req       (slot_req[s]),
      .ptr       (ptr_q[s]),
      .winner    (winner[s]),
      .any_grant (any_win[s])
    );
  end

  // Slots already allocated never look at their arbiter, so a release and a
  // new request on the same slot costs one idle cycle.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      state_d[s] = state_q[s];
      load[s]    = 1'b0;
      case (state_q[s])
        IDLE: begin
          if (any_win[s] && !bus.reg_bank_claim) begin
            state_d[s] = ALLOC;
            load[s]    = 1'b1;
          end
        end
        ALLOC: begin
          if (!bus.valid[owner_q[s]]) state_d[s] = IDLE;
        end
        default: state_d[s] = IDLE;
      endcase
    end
  end

  // ---- slot state / owner / pointer registers ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= IDLE;
        owner_q[s] <= '0;
        ptr_q[s]   <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= state_d[s];
        if (load[s]) begin
          owner_q[s] <= winner[s];
          ptr_q[s]   <= wrap_inc(winner[s]);
        end
      end
    end
  end

  always_comb begin
    owns       = '0;
    bus.enable = '0;
    bus.select = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      for (int v = 0; v < NUM_VCS; v++) begin
        bus.enable[o][v] = (state_q[o*NUM_VCS+v] == ALLOC);
        bus.select[o][v] = owner_q[o*NUM_VCS+v];
        if (state_q[o*NUM_VCS+v] == ALLOC) owns[owner_q[o*NUM_VCS+v]] = 1'b1;
      end
    end
    bus.grant = owns;
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus a randomized run
// scored against a slot-ownership model of the allocation rules.
module tb_switch_allocator;

  localparam int NB = 4;
  localparam int NO = 4;
  localparam int NV = 3;
  localparam int SW = 2;
  localparam int OW = 2;
  localparam int VW = 2;
  localparam int NS = NO * NV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NB-1:0]         valid = '0;
  logic [NB-1:0][OW-1:0] req_out = '0;
  logic [NB-1:0][VW-1:0] req_vc = '0;
  logic                  claim = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  switch_allocator_if #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV)) bus ();

  assign bus.valid          = valid;
  assign bus.req_outport    = req_out;
  assign bus.req_vc         = req_vc;
  assign bus.reg_bank_claim = claim;

  switch_allocator #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // Reference: each slot holds an owner (-1 when free) and a priority pointer.
  int m_own [NS];
  int m_ptr [NS];
  int m_sel [NS];

  always @(posedge clk or posedge rst) begin : model
    int old_own [NS];
    logic [NB-1:0] busy;
    bit taken;
    int cand;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        m_own[s] = -1;
        m_ptr[s] = 0;
        m_sel[s] = 0;
      end
    end else begin
      busy = '0;
      for (int s = 0; s < NS; s++) begin
        old_own[s] = m_own[s];
        if (m_own[s] >= 0) busy[m_own[s]] = 1'b1;
      end
      for (int s = 0; s < NS; s++) begin
        if (old_own[s] >= 0) begin
          if (!valid[old_own[s]]) m_own[s] = -1;
        end else if (!claim) begin
          taken = 1'b0;
          for (int k = 0; k < NB; k++) begin
            cand = (m_ptr[s] + k) % NB;
            if (!taken && valid[cand] && !busy[cand] &&
                int'(req_out[cand]) < NO && int'(req_vc[cand]) < NV &&
                int'(req_out[cand]) * NV + int'(req_vc[cand]) == s) begin
              taken    = 1'b1;
              m_own[s] = cand;
              m_sel[s] = cand;
              m_ptr[s] = (cand + 1) % NB;
            end
          end
        end
      end
    end
  end

  task automatic set_req(input int b, input int o, input int v);
    req_out[b] = OW'(o);
    req_vc[b]  = VW'(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [NO-1:0][NV-1:0] e;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total += 3;
    if (bus.enable !== '0) begin bad++; $display("FAIL reset_enable: got %h want 0", bus.enable); end
    if (bus.grant !== '0)  begin bad++; $display("FAIL reset_grant: got %h want 0", bus.grant); end
    if (bus.select !== '0) begin bad++; $display("FAIL reset_select: got %h want 0", bus.select); end
    @(negedge clk);
    rst = 1'b0;
    valid = 4'b0011;
    set_req(0, 0, 0);
    set_req(1, 1, 1);
    tick();
    total++;
    if (bus.grant !== 4'b0011) begin bad++; $display("FAIL reset_pre_grant: got %b want 0011", bus.grant); end
    #2 rst = 1'b1;
    #1;
    total += 3;
    if (bus.enable !== '0) begin bad++; $display("FAIL midrst_enable: got %h want 0", bus.enable); end
    if (bus.grant !== '0)  begin bad++; $display("FAIL midrst_grant: got %h want 0", bus.grant); end
    if (bus.select !== '0) begin bad++; $display("FAIL midrst_select: got %h want 0", bus.select); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    e = '0;
    e[0][0] = 1'b1;
    e[1][1] = 1'b1;
    total += 2;
    if (bus.grant !== 4'b0011) begin bad++; $display("FAIL postrst_grant: got %b want 0011", bus.grant); end
    if (bus.enable !== e) begin bad++; $display("FAIL postrst_enable: got %h want %h", bus.enable, e); end
    valid = '0;
    tick();
    total++;
    if (bus.grant !== '0) begin bad++; $display("FAIL postrst_release: got %b want 0000", bus.grant); end
  endtask

  task automatic test_single();
    logic [NO-1:0][NV-1:0] e;
    @(negedge clk);
    valid = 4'b0100;
    set_req(2, 1, 0);
    tick();
    e = '0;
    e[1][0] = 1'b1;
    total += 3;
    if (bus.enable !== e) begin bad++; $display("FAIL single_enable: got %h want %h", bus.enable, e); end
    if (bus.select[1][0] !== 2'd2) begin bad++; $display("FAIL single_select: got %0d want 2", bus.select[1][0]); end
    if (bus.grant !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b want 0100", bus.grant); end
    set_req(2, 3, 2);
    tick();
    total += 2;
    if (bus.enable !== e) begin bad++; $display("FAIL single_fieldchg_enable: got %h want %h", bus.enable, e); end
    if (bus.select[1][0] !== 2'd2) begin bad++; $display("FAIL single_fieldchg_select: got %0d want 2", bus.select[1][0]); end
    valid = '0;
    tick();
    total += 2;
    if (bus.enable !== '0) begin bad++; $display("FAIL single_release_enable: got %h want 0", bus.enable); end
    if (bus.grant !== '0) begin bad++; $display("FAIL single_release_grant: got %b want 0000", bus.grant); end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 3, 0};
    @(negedge clk);
    valid = 4'b1011;
    set_req(0, 2, 1);
    set_req(1, 2, 1);
    set_req(3, 2, 1);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++) begin
        tick();
        total += 3;
        if (bus.enable[2][1] !== 1'b1) begin bad++; $display("FAIL rr_enable[%0d.%0d]: got %b want 1", k, c, bus.enable[2][1]); end
        if (bus.select[2][1] !== SW'(order[k])) begin bad++; $display("FAIL rr_owner[%0d.%0d]: got %0d want %0d", k, c, bus.select[2][1], order[k]); end
        if (bus.grant !== (NB'(1) << order[k])) begin bad++; $display("FAIL rr_grant[%0d.%0d]: got %b want %b", k, c, bus.grant, NB'(1) << order[k]); end
      end
      valid[order[k]] = 1'b0;
      tick();
      total += 2;
      if (bus.enable[2][1] !== 1'b0) begin bad++; $display("FAIL rr_bubble_enable[%0d]: got %b want 0", k, bus.enable[2][1]); end
      if (bus.grant !== '0) begin bad++; $display("FAIL rr_bubble_grant[%0d]: got %b want 0000", k, bus.grant); end
      valid[order[k]] = 1'b1;
    end
    valid = '0;
    tick();
  endtask

  task automatic test_independent();
    logic [NO-1:0][NV-1:0] e;
    @(negedge clk);
    valid = 4'b0111;
    set_req(0, 0, 0);
    set_req(1, 0, 1);
    set_req(2, 3, 0);
    tick();
    e = '0;
    e[0][0] = 1'b1;
    e[0][1] = 1'b1;
    e[3][0] = 1'b1;
    total += 3;
    if (bus.enable !== e) begin bad++; $display("FAIL indep_enable: got %h want %h", bus.enable, e); end
    if (bus.grant !== 4'b0111) begin bad++; $display("FAIL indep_grant: got %b want 0111", bus.grant); end
    if ({bus.select[0][0], bus.select[0][1], bus.select[3][0]} !== 6'b00_01_10) begin
      bad++;
      $display("FAIL indep_select: got %0d/%0d/%0d want 0/1/2", bus.select[0][0], bus.select[0][1], bus.select[3][0]);
    end
    valid = '0;
    tick();
    total++;
    if (bus.enable !== '0) begin bad++; $display("FAIL indep_release: got %h want 0", bus.enable); end
  endtask

  task automatic test_claim();
    @(negedge clk);
    valid = 4'b0001;
    set_req(0, 1, 1);
    tick();
    total++;
    if (bus.grant !== 4'b0001) begin bad++; $display("FAIL claim_setup_grant: got %b want 0001", bus.grant); end
    claim = 1'b1;
    valid[1] = 1'b1;
    set_req(1, 2, 0);
    for (int c = 0; c < 5; c++) begin
      tick();
      total += 3;
      if (bus.enable[2][0] !== 1'b0) begin bad++; $display("FAIL claim_block_enable[%0d]: got %b want 0", c, bus.enable[2][0]); end
      if (bus.grant[1] !== 1'b0) begin bad++; $display("FAIL claim_block_grant[%0d]: got %b want 0", c, bus.grant[1]); end
      if (bus.enable[1][1] !== (c < 2)) begin bad++; $display("FAIL claim_hold_release[%0d]: got %b want %b", c, bus.enable[1][1], c < 2); end
      if (c == 1) valid[0] = 1'b0;
    end
    claim = 1'b0;
    tick();
    total += 3;
    if (bus.grant !== 4'b0010) begin bad++; $display("FAIL claim_after_grant: got %b want 0010", bus.grant); end
    if (bus.enable[2][0] !== 1'b1) begin bad++; $display("FAIL claim_after_enable: got %b want 1", bus.enable[2][0]); end
    if (bus.select[2][0] !== 2'd1) begin bad++; $display("FAIL claim_after_select: got %0d want 1", bus.select[2][0]); end
    valid = '0;
    tick();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    valid = 4'b1000;
    set_req(3, 0, 3);
    for (int c = 0; c < 5; c++) begin
      tick();
      total += 2;
      if (bus.grant !== '0) begin bad++; $display("FAIL oor_grant[%0d]: got %b want 0000", c, bus.grant); end
      if (bus.enable !== '0) begin bad++; $display("FAIL oor_enable[%0d]: got %h want 0", c, bus.enable); end
    end
    set_req(3, 0, 1);
    tick();
    total += 3;
    if (bus.grant !== 4'b1000) begin bad++; $display("FAIL oor_fixed_grant: got %b want 1000", bus.grant); end
    if (bus.enable[0][1] !== 1'b1) begin bad++; $display("FAIL oor_fixed_enable: got %b want 1", bus.enable[0][1]); end
    if (bus.select[0][1] !== 2'd3) begin bad++; $display("FAIL oor_fixed_select: got %0d want 3", bus.select[0][1]); end
    valid = '0;
    tick();
  endtask

  task automatic test_random();
    logic [NO-1:0][NV-1:0]         exp_en;
    logic [NB-1:0]                 exp_gr;
    logic [NO-1:0][NV-1:0][SW-1:0] exp_sel;
    logic [NO-1:0][NV-1:0][SW-1:0] got_sel;
    bit owned;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int b = 0; b < NB; b++) begin
        owned = 1'b0;
        for (int s = 0; s < NS; s++) if (m_own[s] == b) owned = 1'b1;
        if (owned) valid[b] = ($urandom_range(0, 7) != 0);
        else       valid[b] = ($urandom_range(0, 1) == 1);
        if (!owned || $urandom_range(0, 4) == 0)
          set_req(b, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
      claim = ($urandom_range(0, 4) == 0);
      tick();
      exp_en  = '0;
      exp_gr  = '0;
      exp_sel = '0;
      got_sel = '0;
      for (int o = 0; o < NO; o++) begin
        for (int v = 0; v < NV; v++) begin
          if (m_own[o*NV+v] >= 0) begin
            exp_en[o][v]  = 1'b1;
            exp_gr[m_own[o*NV+v]] = 1'b1;
            exp_sel[o][v] = SW'(m_sel[o*NV+v]);
            got_sel[o][v] = bus.select[o][v];
          end
        end
      end
      total += 3;
      if (bus.enable !== exp_en) begin bad++; $display("FAIL rand_enable[%0d]: got %h want %h", cyc, bus.enable, exp_en); end
      if (bus.grant !== exp_gr) begin bad++; $display("FAIL rand_grant[%0d]: got %b want %b", cyc, bus.grant, exp_gr); end
      if (got_sel !== exp_sel) begin bad++; $display("FAIL rand_select[%0d]: got %h want %h", cyc, got_sel, exp_sel); end
    end
    claim = 1'b0;
    valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_independent();
    test_claim();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
